vga_timing_gen: RTL and testbench
=================================

// Module: vga_timing_gen
// PURPOSE
//  Parametrised raster timing generator replacing hard-coded 640x480 counters in the adapter top.
//  Produces sync, active-video and pixel coordinates from one clock with a pixel-clock enable.
//  Adds pixel replication (scale), latency-matched delayed sync/blank, frame counter, vblank IRQ.
//  Sits between the clock/PLL block and the text/bitmap controllers, which consume posx/posy.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line        H_FP 16  H_SYNC 96  H_BP 48 (pixels)
//  V_ACTIVE 480  visible lines/frame        V_FP 10  V_SYNC 2   V_BP 33 (lines)
//  HS_POL   0    h_sync asserted level      VS_POL 0  v_sync asserted level
//  PIPE_DLY 2    en-stages of delay on *_d outputs (0 = *_d equal undelayed outputs)
//  FRAME_W  16   frame_cnt width
//  Derived: H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP, V_TOTAL likewise; HW=$clog2(H_TOTAL), VW=$clog2(V_TOTAL)
// PORTS
//  clk         in   1       system clock; all state on posedge
//  rst         in   1       synchronous, active-high reset
//  en          in   1       pixel-clock enable; timing advances only when 1
//  scale       in   2       replication: posx/posy = count >> scale (0..3)
//  irq_ack     in   1       clears vblank_irq
//  h_count     out  HW      horizontal counter 0..H_TOTAL-1
//  v_count     out  VW      vertical counter 0..V_TOTAL-1
//  posx        out  HW      scaled x; 0 outside active columns
//  posy        out  VW      scaled y; 0 outside active lines
//  active      out  1       h_count<H_ACTIVE && v_count<V_ACTIVE
//  h_sync      out  1       horizontal sync, level per HS_POL
//  v_sync      out  1       vertical sync, level per VS_POL
//  active_d    out  1       active delayed PIPE_DLY en-stages
//  h_sync_d    out  1       h_sync delayed PIPE_DLY en-stages
//  v_sync_d    out  1       v_sync delayed PIPE_DLY en-stages
//  line_start  out  1       en && h_count==0
//  frame_start out  1       en && h_count==0 && v_count==0
//  vblank_irq  out  1       sticky flag, set at start of first blank line
//  frame_cnt   out  FRAME_W completed-frame counter
// BEHAVIOUR
//  - Reset: h_count=0, v_count=0, frame_cnt=0, vblank_irq=0; delay stages loaded with active=0,
//    h_sync=~HS_POL, v_sync=~VS_POL. Reset mid-frame restarts at (0,0) next cycle; reset beats en.
//  - Counters: on en, h_count+1; at H_TOTAL-1 wraps to 0 and v_count+1; v_count wraps at V_TOTAL-1.
//    en=0: all registers hold; line_start/frame_start read 0.
//  - Decode (combinational from registered counters, zero latency):
//    h_sync = HS_POL when H_ACTIVE+H_FP <= h_count < H_ACTIVE+H_FP+H_SYNC, else ~HS_POL;
//    v_sync = VS_POL when V_ACTIVE+V_FP <= v_count < V_ACTIVE+V_FP+V_SYNC, else ~VS_POL.
//    v_sync changes with v_count, i.e. aligned to h_count==0, not to h_sync edge.
//  - posx = (h_count<H_ACTIVE) ? h_count>>scale : 0; posy same with v_count/V_ACTIVE.
//    scale change takes effect same cycle; no counter disturbance.
//  - *_d: PIPE_DLY-deep shift register, shifts only on en; matches RAM+ROM latency of controllers.
//  - vblank_irq: set on the clk where en=1 and next state is (h=0, v=V_ACTIVE); cleared on irq_ack=1.
//    Set and ack in same cycle -> set wins (stays 1). Ack while 0 -> no effect.
//  - frame_cnt: +1 on the en cycle where counters wrap (H_TOTAL-1,V_TOTAL-1)->(0,0); modulo 2^FRAME_W.
//  - Parameters must satisfy all porch/sync values >=1; no runtime checking.
// TESTING
//  1 Defaults, en=1: h_sync low for h_count 656..751, line period 800 clk, v_sync low lines 490..491,
//    frame period 420000 clk, active high exactly 307200 clk per frame.
//  2 scale=1: posx sequence 0,0,1,1..319,319 then 0 in blanking; posy 0..239; scale=3 -> posx max 79.
//  3 en toggled 1,0,1,0: counters advance every other clk, line period 1600 clk; line_start only on en.
//  4 PIPE_DLY=3: active_d rises 3 en-cycles after active; with en gaps, delay stays 3 en-cycles.
//  5 IRQ: vblank_irq sets entering v_count=480,h=0; ack at frame 1 clears; ack held on next set cycle
//    -> irq stays 1; frame_cnt with FRAME_W=2 counts 1,2,3,0 over four frames.
//  6 rst asserted at h=300,v=100 for 1 clk: next cycle h=0,v=0, irq=0, frame_cnt=0, *_d inactive.

Source files
------------

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: counters, sync/blank decode, pixel replication,
// PIPE_DLY-stage delayed sync/blank, completed-frame counter and sticky vblank interrupt.
module vga_timing_gen #(
   parameter int H_ACTIVE = 640,
   parameter int H_FP     = 16,
   parameter int H_SYNC   = 96,
   parameter int H_BP     = 48,
   parameter int V_ACTIVE = 480,
   parameter int V_FP     = 10,
   parameter int V_SYNC   = 2,
   parameter int V_BP     = 33,
   parameter bit HS_POL   = 1'b0,
   parameter bit VS_POL   = 1'b0,
   parameter int PIPE_DLY = 2,
   parameter int FRAME_W  = 16,
   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP,
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP,
   localparam int HW      = $clog2(H_TOTAL),
   localparam int VW      = $clog2(V_TOTAL)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   input  logic [1:0]         scale,
   input  logic               irq_ack,
   output logic [HW-1:0]      h_count,
   output logic [VW-1:0]      v_count,
   output logic [HW-1:0]      posx,
   output logic [VW-1:0]      posy,
   output logic               active,
   output logic               h_sync,
   output logic               v_sync,
   output logic               active_d,
   output logic               h_sync_d,
   output logic               v_sync_d,
   output logic               line_start,
   output logic               frame_start,
   output logic               vblank_irq,
   output logic [FRAME_W-1:0] frame_cnt
);

   logic [HW-1:0]      r_h_count;
   logic [VW-1:0]      r_v_count;
   logic [FRAME_W-1:0] r_frame_cnt;
   logic               r_irq;
   logic               w_h_last;
   logic               w_v_last;
   logic               w_h_act;
   logic               w_v_act;
   logic               w_active;
   logic               w_h_sync;
   logic               w_v_sync;
   logic               w_irq_set;

   assign w_h_last  = (r_h_count == HW'(H_TOTAL - 1));
   assign w_v_last  = (r_v_count == VW'(V_TOTAL - 1));
   assign w_h_act   = (r_h_count < HW'(H_ACTIVE));
   assign w_v_act   = (r_v_count < VW'(V_ACTIVE));
   assign w_active  = w_h_act && w_v_act;
   assign w_h_sync  = (r_h_count >= HW'(H_ACTIVE + H_FP) &&
                       r_h_count <  HW'(H_ACTIVE + H_FP + H_SYNC)) ? HS_POL : ~HS_POL;
   assign w_v_sync  = (r_v_count >= VW'(V_ACTIVE + V_FP) &&
                       r_v_count <  VW'(V_ACTIVE + V_FP + V_SYNC)) ? VS_POL : ~VS_POL;
   // The next state is (0, V_ACTIVE) exactly when the last pixel of line V_ACTIVE-1 advances.
   assign w_irq_set = en && w_h_last && (r_v_count == VW'(V_ACTIVE - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_h_count   <= '0;
         r_v_count   <= '0;
         r_frame_cnt <= '0;
      end else if (en) begin
         if (w_h_last) begin
            r_h_count <= '0;
            if (w_v_last) begin
               r_v_count   <= '0;
               r_frame_cnt <= r_frame_cnt + FRAME_W'(1);
            end else begin
               r_v_count <= r_v_count + VW'(1);
            end
         end else begin
            r_h_count <= r_h_count + HW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst)            r_irq <= 1'b0;
      else if (w_irq_set) r_irq <= 1'b1;
      else if (irq_ack)   r_irq <= 1'b0;
   end

   generate
      if (PIPE_DLY == 0) begin : g_nodly
         assign active_d = w_active;
         assign h_sync_d = w_h_sync;
         assign v_sync_d = w_v_sync;
      end else begin : g_dly
         logic [PIPE_DLY-1:0] r_act_sr;
         logic [PIPE_DLY-1:0] r_hs_sr;
         logic [PIPE_DLY-1:0] r_vs_sr;

         always_ff @(posedge clk) begin
            if (rst) begin
               r_act_sr <= '0;
               r_hs_sr  <= {PIPE_DLY{~HS_POL}};
               r_vs_sr  <= {PIPE_DLY{~VS_POL}};
            end else if (en) begin
               r_act_sr[0] <= w_active;
               r_hs_sr[0]  <= w_h_sync;
               r_vs_sr[0]  <= w_v_sync;
               for (int unsigned i = 1; i < PIPE_DLY; i++) begin
                  r_act_sr[i] <= r_act_sr[i-1];
                  r_hs_sr[i]  <= r_hs_sr[i-1];
                  r_vs_sr[i]  <= r_vs_sr[i-1];
               end
            end
         end

         assign active_d = r_act_sr[PIPE_DLY-1];
         assign h_sync_d = r_hs_sr[PIPE_DLY-1];
         assign v_sync_d = r_vs_sr[PIPE_DLY-1];
      end
   endgenerate

   assign h_count     = r_h_count;
   assign v_count     = r_v_count;
   assign posx        = w_h_act ? (r_h_count >> scale) : '0;
   assign posy        = w_v_act ? (r_v_count >> scale) : '0;
   assign active      = w_active;
   assign h_sync      = w_h_sync;
   assign v_sync      = w_v_sync;
   assign line_start  = en && (r_h_count == '0);
   assign frame_start = en && (r_h_count == '0) && (r_v_count == '0);
   assign vblank_irq  = r_irq;
   assign frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Self-checking bench: default-geometry instance checked from a position table, two tiny-geometry
// instances (PIPE_DLY 3 and 0) checked every cycle against an en-count based scoreboard model.
module tb_vga_timing_gen;

   localparam int HA = 8, HF = 2, HSN = 3, HBP = 2;
   localparam int VA = 6, VF = 1, VSN = 2, VBP = 1;
   localparam int HT = HA + HF + HSN + HBP;   // 15
   localparam int VT = VA + VF + VSN + VBP;   // 10
   localparam int FR = HT * VT;               // 150
   localparam int PD = 3;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en = 1'b0;
   logic       irq_ack = 1'b0;
   logic [1:0] scale = 2'd0;

   always #5 clk = ~clk;

   logic [9:0] a_h, a_v, a_px, a_py;
   logic       a_act, a_hs, a_vs, a_ad, a_hsd, a_vsd, a_ls, a_fs, a_irq;
   logic [15:0] a_fc;
   logic [3:0] b_h, b_v, b_px, b_py, c_h, c_v, c_px, c_py;
   logic       b_act, b_hs, b_vs, b_ad, b_hsd, b_vsd, b_ls, b_fs, b_irq;
   logic       c_act, c_hs, c_vs, c_ad, c_hsd, c_vsd, c_ls, c_fs, c_irq;
   logic [1:0] b_fc, c_fc;

   vga_timing_gen u_a (
      .clk(clk), .rst(rst), .en(en), .scale(scale), .irq_ack(irq_ack),
      .h_count(a_h), .v_count(a_v), .posx(a_px), .posy(a_py), .active(a_act),
      .h_sync(a_hs), .v_sync(a_vs), .active_d(a_ad), .h_sync_d(a_hsd), .v_sync_d(a_vsd),
      .line_start(a_ls), .frame_start(a_fs), .vblank_irq(a_irq), .frame_cnt(a_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSN), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSN), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(PD), .FRAME_W(2)
   ) u_b (
      .clk(clk), .rst(rst), .en(en), .scale(scale), .irq_ack(irq_ack),
      .h_count(b_h), .v_count(b_v), .posx(b_px), .posy(b_py), .active(b_act),
      .h_sync(b_hs), .v_sync(b_vs), .active_d(b_ad), .h_sync_d(b_hsd), .v_sync_d(b_vsd),
      .line_start(b_ls), .frame_start(b_fs), .vblank_irq(b_irq), .frame_cnt(b_fc)
   );

   vga_timing_gen #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSN), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSN), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b0), .PIPE_DLY(0), .FRAME_W(2)
   ) u_c (
      .clk(clk), .rst(rst), .en(en), .scale(scale), .irq_ack(irq_ack),
      .h_count(c_h), .v_count(c_v), .posx(c_px), .posy(c_py), .active(c_act),
      .h_sync(c_hs), .v_sync(c_vs), .active_d(c_ad), .h_sync_d(c_hsd), .v_sync_d(c_vsd),
      .line_start(c_ls), .frame_start(c_fs), .vblank_irq(c_irq), .frame_cnt(c_fc)
   );

   typedef struct {
      int h, v, px, py;
      bit act, hs, vs;
   } pos_t;

   typedef struct {
      int h, v, px, py;
      bit act, hs, vs, ad, hsd, vsd, ls, fs, irq;
      int fc;
   } exp_t;

   typedef struct {
      int         e;
      logic [1:0] sc;
      int         h, v, px, py;
      bit         act, hs, ls;
   } vec_t;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   m_e = 0;
   bit   m_irq = 1'b0;
   exp_t sb[$];

   // Raster position of the small geometry after e enable cycles from reset.
   function automatic pos_t at(input int e, input int sc);
      pos_t p;
      p.h   = e % HT;
      p.v   = (e / HT) % VT;
      p.act = (p.h < HA) && (p.v < VA);
      p.hs  = (p.h >= HA + HF && p.h < HA + HF + HSN);
      p.vs  = !(p.v >= VA + VF && p.v < VA + VF + VSN);
      p.px  = (p.h < HA) ? (p.h >> sc) : 0;
      p.py  = (p.v < VA) ? (p.v >> sc) : 0;
      return p;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
      end
   endtask

   task automatic step(input bit r, input bit e, input bit ack, input logic [1:0] sc);
      exp_t x;
      pos_t p, d;
      @(negedge clk);
      rst = r; en = e; irq_ack = ack; scale = sc;
      if (r) begin
         m_e = 0;
         m_irq = 1'b0;
      end else begin
         if (e) m_e++;
         p = at(m_e, sc);
         if (e && p.h == 0 && p.v == VA) m_irq = 1'b1;
         else if (ack)                   m_irq = 1'b0;
      end
      p = at(m_e, sc);
      if (m_e >= PD) d = at(m_e - PD, 0);
      else begin
         d = p;
         d.act = 1'b0; d.hs = 1'b0; d.vs = 1'b1;
      end
      x.h = p.h; x.v = p.v; x.px = p.px; x.py = p.py;
      x.act = p.act; x.hs = p.hs; x.vs = p.vs;
      x.ad = d.act; x.hsd = d.hs; x.vsd = d.vs;
      x.ls = e && (p.h == 0);
      x.fs = e && (p.h == 0) && (p.v == 0);
      x.irq = m_irq;
      x.fc = (m_e / FR) % 4;
      sb.push_back(x);
      @(posedge clk);
      #1;
      x = sb.pop_front();
      chk("b_h", 32'(b_h), x.h);       chk("b_v", 32'(b_v), x.v);
      chk("b_posx", 32'(b_px), x.px);  chk("b_posy", 32'(b_py), x.py);
      chk("b_active", 32'(b_act), 32'(x.act));
      chk("b_hsync", 32'(b_hs), 32'(x.hs));
      chk("b_vsync", 32'(b_vs), 32'(x.vs));
      chk("b_active_d", 32'(b_ad), 32'(x.ad));
      chk("b_hsync_d", 32'(b_hsd), 32'(x.hsd));
      chk("b_vsync_d", 32'(b_vsd), 32'(x.vsd));
      chk("b_line_start", 32'(b_ls), 32'(x.ls));
      chk("b_frame_start", 32'(b_fs), 32'(x.fs));
      chk("b_irq", 32'(b_irq), 32'(x.irq));
      chk("b_frame_cnt", 32'(b_fc), x.fc);
      chk("c_h", 32'(c_h), x.h);       chk("c_v", 32'(c_v), x.v);
      chk("c_posx", 32'(c_px), x.px);
      chk("c_active_d", 32'(c_ad), 32'(x.act));
      chk("c_hsync_d", 32'(c_hsd), 32'(x.hs));
      chk("c_vsync_d", 32'(c_vsd), 32'(x.vs));
      chk("c_line_start", 32'(c_ls), 32'(x.ls));
      chk("c_irq", 32'(c_irq), 32'(x.irq));
      chk("c_frame_cnt", 32'(c_fc), x.fc);
   endtask

   initial begin
      vec_t tbl[14];
      tbl = '{
         '{0,    2'd0,   0, 0,   0, 0, 1'b1, 1'b1, 1'b1},
         '{639,  2'd0, 639, 0, 639, 0, 1'b1, 1'b1, 1'b0},
         '{640,  2'd0, 640, 0,   0, 0, 1'b0, 1'b1, 1'b0},
         '{655,  2'd0, 655, 0,   0, 0, 1'b0, 1'b1, 1'b0},
         '{656,  2'd0, 656, 0,   0, 0, 1'b0, 1'b0, 1'b0},
         '{751,  2'd0, 751, 0,   0, 0, 1'b0, 1'b0, 1'b0},
         '{752,  2'd0, 752, 0,   0, 0, 1'b0, 1'b1, 1'b0},
         '{799,  2'd0, 799, 0,   0, 0, 1'b0, 1'b1, 1'b0},
         '{800,  2'd0,   0, 1,   0, 1, 1'b1, 1'b1, 1'b1},
         '{1439, 2'd1, 639, 1, 319, 0, 1'b1, 1'b1, 1'b0},
         '{1440, 2'd1, 640, 1,   0, 0, 1'b0, 1'b1, 1'b0},
         '{1602, 2'd1,   2, 2,   1, 1, 1'b1, 1'b1, 1'b0},
         '{2239, 2'd3, 639, 2,  79, 0, 1'b1, 1'b1, 1'b0},
         '{2240, 2'd3, 640, 2,   0, 0, 1'b0, 1'b1, 1'b0}
      };

      step(1'b1, 1'b1, 1'b0, 2'd0);
      chk("a_rst_h", 32'(a_h), 0);          chk("a_rst_v", 32'(a_v), 0);
      chk("a_rst_irq", 32'(a_irq), 0);      chk("a_rst_fc", 32'(a_fc), 0);
      chk("a_rst_active_d", 32'(a_ad), 0);  chk("a_rst_hsync_d", 32'(a_hsd), 1);
      chk("a_rst_vsync_d", 32'(a_vsd), 1);

      for (int i = 0; i < 14; i++) begin
         while (m_e < tbl[i].e) step(1'b0, 1'b1, 1'b0, tbl[i].sc);
         chk("a_tbl_h", 32'(a_h), tbl[i].h);
         chk("a_tbl_v", 32'(a_v), tbl[i].v);
         chk("a_tbl_posx", 32'(a_px), tbl[i].px);
         chk("a_tbl_posy", 32'(a_py), tbl[i].py);
         chk("a_tbl_active", 32'(a_act), 32'(tbl[i].act));
         chk("a_tbl_hsync", 32'(a_hs), 32'(tbl[i].hs));
         chk("a_tbl_vsync", 32'(a_vs), 1);
         chk("a_tbl_line_start", 32'(a_ls), 32'(tbl[i].ls));
      end

      // Mid-frame reset (A at h=700, v=2; B has a sticky irq and a nonzero frame count).
      while (m_e < 2300) step(1'b0, 1'b1, 1'b0, 2'd0);
      step(1'b1, 1'b1, 1'b0, 2'd0);
      chk("a_mid_rst_h", 32'(a_h), 0);      chk("a_mid_rst_v", 32'(a_v), 0);
      chk("a_mid_rst_active_d", 32'(a_ad), 0);
      chk("a_mid_rst_hsync_d", 32'(a_hsd), 1);
      chk("b_mid_rst_irq", 32'(b_irq), 0);  chk("b_mid_rst_fc", 32'(b_fc), 0);

      // Frame counter wraps 1,2,3,0 with a 2-bit width.
      for (int k = 1; k <= 4; k++) begin
         for (int j = 0; j < FR; j++) step(1'b0, 1'b1, 1'b0, 2'd0);
         chk("b_frame_wrap", 32'(b_fc), k % 4);
      end

      // Irq: ack held on the set cycle keeps it set, a later ack clears, ack while clear is inert.
      step(1'b1, 1'b1, 1'b0, 2'd0);
      for (int j = 0; j < VA * HT - 1; j++) step(1'b0, 1'b1, 1'b0, 2'd0);
      chk("b_irq_before_set", 32'(b_irq), 0);
      step(1'b0, 1'b1, 1'b1, 2'd0);
      chk("b_irq_set_wins", 32'(b_irq), 1);
      step(1'b0, 1'b1, 1'b1, 2'd0);
      chk("b_irq_ack_clear", 32'(b_irq), 0);
      step(1'b0, 1'b1, 1'b1, 2'd0);
      chk("b_irq_ack_idle", 32'(b_irq), 0);

      // Alternating en: one line takes 2*HT clocks; line_start only on enabled cycles.
      step(1'b1, 1'b1, 1'b0, 2'd0);
      for (int j = 0; j < 2 * HT - 1; j++) step(1'b0, (j % 2) == 0, 1'b0, 2'd0);
      chk("b_toggle_h", 32'(b_h), 0);       chk("b_toggle_v", 32'(b_v), 1);
      chk("b_toggle_ls_on", 32'(b_ls), 1);
      step(1'b0, 1'b0, 1'b0, 2'd0);
      chk("b_toggle_hold_h", 32'(b_h), 0);  chk("b_toggle_ls_off", 32'(b_ls), 0);

      for (int j = 0; j < 3000; j++) begin
         bit r, e, a;
         r = ($urandom_range(0, 499) == 0);
         e = ($urandom_range(0, 3) != 0);
         a = e && ($urandom_range(0, 19) == 0);
         step(r, e, a, 2'($urandom_range(0, 3)));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
